// File: rtl/timemark_cmd_responder.sv
// rtl/timemark_cmd_responder.sv - cycle timemark owner answering GET_TIME / WAIT_CLK / CLR_TIME commands
// Optional feature macro: TIMEMARK_WAIT_ABORT_EN (adds wait_abort input to cut a WAIT short).
module timemark_cmd_responder #(
    parameter int TM_W  = 64,
    parameter int ARG_W = 32
) (
    input  logic             source_clock,
    input  logic             source_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_op,
    output logic             rsp_err,
    output logic [TM_W-1:0]  rsp_data,
    output logic [TM_W-1:0]  timemark,
`ifdef TIMEMARK_WAIT_ABORT_EN
    input  logic             wait_abort,
`endif
    output logic             busy
);

    localparam logic [1:0] OP_GET  = 2'd0;
    localparam logic [1:0] OP_WAIT = 2'd1;
    localparam logic [1:0] OP_CLR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ARG_W-1:0] wait_cnt;
    logic [TM_W-1:0]  tm_next;
    logic             accept;
    logic             wait_done;
    logic             abort;

`ifdef TIMEMARK_WAIT_ABORT_EN
    assign abort = wait_abort;
`else
    assign abort = 1'b0;
`endif

    assign tm_next   = timemark + 1'b1;
    assign cmd_ready = (state_q == ST_IDLE) && !source_reset;
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        wait_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_op == OP_WAIT && cmd_arg != '0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // count reaching 1 means this edge completes the n-th waiting cycle
                if (abort || wait_cnt == {{(ARG_W-1){1'b0}}, 1'b1}) begin
                    wait_done = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge source_clock) begin
        if (source_reset) begin
            state_q  <= ST_IDLE;
            timemark <= '0;
            wait_cnt <= '0;
            rsp_op   <= 2'd0;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
        end else begin
            state_q  <= state_d;
            timemark <= (accept && cmd_op == OP_CLR) ? '0 : tm_next;
            if (accept) begin
                rsp_op   <= cmd_op;
                wait_cnt <= cmd_arg;
                case (cmd_op)
                    OP_GET, OP_CLR: begin
                        rsp_data <= timemark;
                        rsp_err  <= 1'b0;
                    end
                    OP_WAIT: begin
                        // completion stamp: the value timemark shows while rsp_valid is high
                        rsp_data <= tm_next;
                        rsp_err  <= 1'b0;
                    end
                    default: begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                endcase
            end else if (state_q == ST_WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
                if (wait_done) begin
                    rsp_data <= tm_next;
                    rsp_err  <= abort;
                end
            end
        end
    end

endmodule

// File: tb/tb_timemark_cmd_responder.sv
// tb/tb_timemark_cmd_responder.sv - directed self-checking bench for timemark_cmd_responder
module tb_timemark_cmd_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [1:0]  cmd_op, rsp_op;
    logic [31:0] cmd_arg;
    logic [63:0] rsp_data, timemark;

    logic        s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready, s_rsp_err, s_busy;
    logic [1:0]  s_cmd_op, s_rsp_op;
    logic [3:0]  s_cmd_arg, s_rsp_data, s_timemark;

`ifdef TIMEMARK_WAIT_ABORT_EN
    logic        abort_in;
    logic        s_abort_in;
`endif

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] tm;
    logic [3:0]  tms;
    logic        clr_b = 1'b0;
    logic        clr_s = 1'b0;
    logic [63:0] snap;
    int          lat;
    int          seen;

    always #5 clk = ~clk;

    timemark_cmd_responder #(.TM_W(64), .ARG_W(32)) dut (
        .source_clock(clk),
        .source_reset(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_arg(cmd_arg),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_op(rsp_op),
        .rsp_err(rsp_err),
        .rsp_data(rsp_data),
        .timemark(timemark),
`ifdef TIMEMARK_WAIT_ABORT_EN
        .wait_abort(abort_in),
`endif
        .busy(busy)
    );

    // narrow instance so counter wrap and the maximum wait argument are reachable
    timemark_cmd_responder #(.TM_W(4), .ARG_W(4)) dus (
        .source_clock(clk),
        .source_reset(rst),
        .cmd_valid(s_cmd_valid),
        .cmd_ready(s_cmd_ready),
        .cmd_op(s_cmd_op),
        .cmd_arg(s_cmd_arg),
        .rsp_valid(s_rsp_valid),
        .rsp_ready(s_rsp_ready),
        .rsp_op(s_rsp_op),
        .rsp_err(s_rsp_err),
        .rsp_data(s_rsp_data),
        .timemark(s_timemark),
`ifdef TIMEMARK_WAIT_ABORT_EN
        .wait_abort(s_abort_in),
`endif
        .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tm    = clr_b ? 64'd0 : tm + 64'd1;
        tms   = clr_s ? 4'd0 : tms + 4'd1;
        clr_b = 1'b0;
        clr_s = 1'b0;
    endtask

    task automatic wait_big(output int l);
        l = 1;
        while (rsp_valid !== 1'b1 && l < 100) begin
            tick();
            l++;
        end
    endtask

    task automatic wait_small(output int l);
        l = 1;
        while (s_rsp_valid !== 1'b1 && l < 100) begin
            chk("s_tm_run", {60'd0, s_timemark}, {60'd0, tms});
            tick();
            l++;
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 32'd0; rsp_ready = 1'b1;
        s_cmd_valid = 1'b0; s_cmd_op = 2'd0; s_cmd_arg = 4'd0; s_rsp_ready = 1'b1;
`ifdef TIMEMARK_WAIT_ABORT_EN
        abort_in = 1'b0; s_abort_in = 1'b0;
`endif
        tm = 64'd0; tms = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tm", timemark, 64'd0);
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_data", rsp_data, 64'd0);
        chk("rst_op_err", {61'd0, rsp_op, rsp_err}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", {63'd0, cmd_ready}, 64'd1);
        tm = 64'd0; tms = 4'd0;
        tick();
        chk("count_1", timemark, 64'd1);
        tick();
        chk("count_2", timemark, 64'd2);

        // GET_TIME at timemark 10
        while (tm != 64'd10) tick();
        cmd_valid = 1'b1; cmd_op = 2'd0;
        tick();
        cmd_valid = 1'b0;
        chk("get_valid", {63'd0, rsp_valid}, 64'd1);
        chk("get_data", rsp_data, 64'd10);
        chk("get_err", {63'd0, rsp_err}, 64'd0);
        chk("get_ready", {63'd0, cmd_ready}, 64'd0);
        tick();
        chk("get_done", {62'd0, rsp_valid, cmd_ready}, 64'd1);

        // WAIT_CLK 5 and 0
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 32'd5;
        tick();
        cmd_valid = 1'b0;
        wait_big(lat);
        chk("wait5_lat", 64'(lat), 64'd6);
        chk("wait5_data", rsp_data, tm);
        chk("wait5_op", {62'd0, rsp_op}, 64'd1);
        tick();
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 32'd0;
        tick();
        cmd_valid = 1'b0;
        wait_big(lat);
        chk("wait0_lat", 64'(lat), 64'd1);
        chk("wait0_data", rsp_data, tm);
        tick();

        // CLR_TIME at timemark 100
        while (tm != 64'd100) tick();
        cmd_valid = 1'b1; cmd_op = 2'd2;
        clr_b = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("clr_tm", timemark, 64'd0);
        chk("clr_data", rsp_data, 64'd100);
        tick();
        chk("clr_count", timemark, 64'd1);

        // reserved op
        cmd_valid = 1'b1; cmd_op = 2'd3;
        tick();
        cmd_valid = 1'b0;
        chk("rsv_err", {63'd0, rsp_err}, 64'd1);
        chk("rsv_data", rsp_data, 64'd0);
        chk("rsv_op", {62'd0, rsp_op}, 64'd3);
        tick();

        // stall with a CLR held by the sender, then back-to-back acceptance
        rsp_ready = 1'b0;
        snap = tm;
        cmd_valid = 1'b1; cmd_op = 2'd0;
        tick();
        cmd_op = 2'd2;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {63'd0, rsp_valid}, 64'd1);
            chk("stall_data", rsp_data, snap);
            chk("stall_ready", {63'd0, cmd_ready}, 64'd0);
            tick();
        end
        chk("stall_tm", timemark, tm);
        rsp_ready = 1'b1;
        tick();
        chk("b2b_idle", {62'd0, rsp_valid, cmd_ready}, 64'd1);
        snap = tm;
        clr_b = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("b2b_data", rsp_data, snap);
        chk("b2b_clr", timemark, 64'd0);
        tick();

        // reset in the middle of a wait
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 32'd20;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        chk("wait_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tm = 64'd0; tms = 4'd0;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_tm", timemark, 64'd0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        chk("mid_rst_no_rsp", 64'(seen), 64'd0);
        chk("mid_rst_count", timemark, tm);

        // narrow instance: wrap during WAIT_CLK 3, max wait, clear at wrap
        while (tms != 4'd14) tick();
        s_cmd_valid = 1'b1; s_cmd_op = 2'd1; s_cmd_arg = 4'd3;
        tick();
        s_cmd_valid = 1'b0;
        wait_small(lat);
        chk("wrap_lat", 64'(lat), 64'd4);
        chk("wrap_data", {60'd0, s_rsp_data}, 64'd2);
        tick();
        s_cmd_valid = 1'b1; s_cmd_op = 2'd1; s_cmd_arg = 4'd15;
        tick();
        s_cmd_valid = 1'b0;
        wait_small(lat);
        chk("max_lat", 64'(lat), 64'd16);
        chk("max_data", {60'd0, s_rsp_data}, {60'd0, tms});
        tick();
        while (tms != 4'd15) tick();
        s_cmd_valid = 1'b1; s_cmd_op = 2'd2;
        clr_s = 1'b1;
        tick();
        s_cmd_valid = 1'b0;
        chk("clr_wrap_tm", {60'd0, s_timemark}, 64'd0);
        chk("clr_wrap_data", {60'd0, s_rsp_data}, 64'd15);
        tick();
        chk("clr_wrap_cnt", {60'd0, s_timemark}, 64'd1);

`ifdef TIMEMARK_WAIT_ABORT_EN
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 32'd50;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("abort_valid", {63'd0, rsp_valid}, 64'd1);
        chk("abort_err", {63'd0, rsp_err}, 64'd1);
        chk("abort_op", {62'd0, rsp_op}, 64'd1);
        chk("abort_data", rsp_data, tm);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
